// File: rtl/sdram_responder_if.sv
// SDRAM pin bus between a controller (master) and the chip-side responder (slave).
// dq_in is the data bus as seen from the chip; dq_out/dq_oe is the chip's read drive.
interface sdram_responder_if;
    logic        SDRAM_CKE;
    logic        SDRAM_nCS;
    logic        SDRAM_nRAS;
    logic        SDRAM_nCAS;
    logic        SDRAM_nWE;
    logic [1:0]  SDRAM_BA;
    logic [12:0] SDRAM_A;
    logic        SDRAM_DQML;
    logic        SDRAM_DQMH;
    logic [15:0] dq_in;
    logic [15:0] dq_out;
    logic        dq_oe;

    // Handshake: no valid/ready; a command is accepted on every rising clk edge
    // with SDRAM_CKE=1, and read words appear with dq_oe=1 exactly CL+k cycles later.
    modport master (
        output SDRAM_CKE, SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE,
        output SDRAM_BA, SDRAM_A, SDRAM_DQML, SDRAM_DQMH, dq_in,
        input  dq_out, dq_oe
    );

    modport slave (
        input  SDRAM_CKE, SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE,
        input  SDRAM_BA, SDRAM_A, SDRAM_DQML, SDRAM_DQMH, dq_in,
        output dq_out, dq_oe
    );
endinterface

// File: rtl/sdram_responder.sv
// Chip-side SDRAM responder backed by block RAM: command decode, CL2/CL3 read pipe, bursts, error capture.
// Optional tRCD checking is compiled in when SDRAM_TIMING_CHECK_EN is defined.
module sdram_responder #(
    parameter int MEM_AW = 12,
    parameter int TRCD   = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    sdram_responder_if.slave     sd,
    output logic [12:0]          mode_reg,
    output logic                 mode_valid,
    output logic [15:0]          refresh_cnt,
    output logic                 err,
    output logic [2:0]           err_code
);
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_LMR = 4'b0000;
    localparam logic [3:0] CMD_BST = 4'b0110;

    logic [15:0] mem [2**MEM_AW];

    logic [3:0]  bank_open;
    logic [12:0] open_row [4];

    logic [2:0]  burst_left;
    logic        burst_rd;
    logic [1:0]  burst_ba;
    logic [8:0]  burst_col;
    logic [2:0]  burst_mask;
    logic        burst_ap;

    logic [15:0] ram_q;
    logic        rd_v1;
    logic        p2_v;
    logic [15:0] p2_d;

    logic [3:0]  cmd;
    logic        cmd_act, cmd_rd, cmd_wr, cmd_pre, cmd_ref, cmd_lmr, cmd_bst;
    logic [2:0]  bl_mask;
    logic        cl3;
    logic        acc_cmd, trunc, burst_go, acc_en, acc_rd;
    logic [1:0]  acc_ba;
    logic [8:0]  acc_col, next_col;
    logic [2:0]  acc_mask;
    logic [MEM_AW-1:0] acc_addr;
    logic        err_set;
    logic [2:0]  err_val;

`ifdef SDRAM_TIMING_CHECK_EN
    localparam logic [7:0] TRCD_C = 8'(TRCD);
    logic [7:0] trcd_cnt [4];
`endif

    assign cmd = {sd.SDRAM_nCS, sd.SDRAM_nRAS, sd.SDRAM_nCAS, sd.SDRAM_nWE};

    always_comb begin
        cmd_act = sd.SDRAM_CKE && (cmd == CMD_ACT);
        cmd_rd  = sd.SDRAM_CKE && (cmd == CMD_RD);
        cmd_wr  = sd.SDRAM_CKE && (cmd == CMD_WR);
        cmd_pre = sd.SDRAM_CKE && (cmd == CMD_PRE);
        cmd_ref = sd.SDRAM_CKE && (cmd == CMD_REF);
        cmd_lmr = sd.SDRAM_CKE && (cmd == CMD_LMR);
        cmd_bst = sd.SDRAM_CKE && (cmd == CMD_BST);

        case (mode_reg[2:0])
            3'b001:  bl_mask = 3'd1;
            3'b010:  bl_mask = 3'd3;
            3'b011:  bl_mask = 3'd7;
            default: bl_mask = 3'd0;
        endcase
        cl3 = (mode_reg[6:4] == 3'd3);

        // Accesses to a closed bank are dropped entirely and do not disturb a running burst.
        acc_cmd  = (cmd_rd || cmd_wr) && bank_open[sd.SDRAM_BA];
        trunc    = acc_cmd || cmd_bst ||
                   (cmd_pre && (sd.SDRAM_A[10] || (sd.SDRAM_BA == burst_ba)));
        burst_go = sd.SDRAM_CKE && (burst_left != 3'd0) && !trunc;
        acc_en   = reset_n && (acc_cmd || burst_go);
        acc_rd   = acc_cmd ? cmd_rd : burst_rd;
        acc_ba   = acc_cmd ? sd.SDRAM_BA : burst_ba;
        acc_col  = acc_cmd ? sd.SDRAM_A[8:0] : burst_col;
        acc_mask = acc_cmd ? bl_mask : burst_mask;
        acc_addr = MEM_AW'({acc_ba, open_row[acc_ba], acc_col});
        // Column wraps inside the BL-aligned block.
        next_col = {acc_col[8:3],
                    (acc_col[2:0] & ~acc_mask) | ((acc_col[2:0] + 3'd1) & acc_mask)};

        err_set = 1'b1;
        err_val = 3'd0;
        if ((cmd_rd || cmd_wr) && !bank_open[sd.SDRAM_BA])
            err_val = 3'd1;
        else if ((cmd_rd || cmd_wr) && !mode_valid)
            err_val = 3'd3;
`ifdef SDRAM_TIMING_CHECK_EN
        else if ((cmd_rd || cmd_wr) && (trcd_cnt[sd.SDRAM_BA] < TRCD_C))
            err_val = 3'd5;
`endif
        else if (cmd_act && bank_open[sd.SDRAM_BA])
            err_val = 3'd2;
        else if (cmd_ref && (bank_open != 4'd0))
            err_val = 3'd4;
        else
            err_set = 1'b0;
    end

    // Backing RAM: never reset so contents survive reset_n.
    always_ff @(posedge clk) begin
        if (acc_en && !acc_rd) begin
            if (!sd.SDRAM_DQML) mem[acc_addr][7:0]  <= sd.dq_in[7:0];
            if (!sd.SDRAM_DQMH) mem[acc_addr][15:8] <= sd.dq_in[15:8];
        end
        if (acc_en && acc_rd)
            ram_q <= mem[acc_addr];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sd.dq_out   <= 16'd0;
            sd.dq_oe    <= 1'b0;
            mode_reg    <= 13'd0;
            mode_valid  <= 1'b0;
            refresh_cnt <= 16'd0;
            err         <= 1'b0;
            err_code    <= 3'd0;
            bank_open   <= 4'd0;
            burst_left  <= 3'd0;
            burst_rd    <= 1'b0;
            burst_ba    <= 2'd0;
            burst_col   <= 9'd0;
            burst_mask  <= 3'd0;
            burst_ap    <= 1'b0;
            rd_v1       <= 1'b0;
            p2_v        <= 1'b0;
            p2_d        <= 16'd0;
            for (int b = 0; b < 4; b++) open_row[b] <= 13'd0;
`ifdef SDRAM_TIMING_CHECK_EN
            for (int b = 0; b < 4; b++) trcd_cnt[b] <= TRCD_C;
`endif
        end else if (sd.SDRAM_CKE) begin
            // ram_q is one cycle behind the issue edge; CL3 adds the p2 stage.
            rd_v1 <= acc_en && acc_rd;
            p2_v  <= rd_v1;
            p2_d  <= ram_q;
            sd.dq_oe <= cl3 ? p2_v : rd_v1;
            if (cl3 ? p2_v : rd_v1)
                sd.dq_out <= cl3 ? p2_d : ram_q;

            if (acc_cmd) begin
                burst_rd   <= cmd_rd;
                burst_ba   <= sd.SDRAM_BA;
                burst_col  <= next_col;
                burst_mask <= bl_mask;
                burst_ap   <= sd.SDRAM_A[10];
                burst_left <= (cmd_wr && mode_reg[9]) ? 3'd0 : bl_mask;
                if (sd.SDRAM_A[10] && ((cmd_wr && mode_reg[9]) || bl_mask == 3'd0))
                    bank_open[sd.SDRAM_BA] <= 1'b0;
            end else if (trunc) begin
                burst_left <= 3'd0;
            end else if (burst_go) begin
                burst_col  <= next_col;
                burst_left <= burst_left - 3'd1;
                if (burst_left == 3'd1 && burst_ap)
                    bank_open[burst_ba] <= 1'b0;
            end

            if (cmd_act) begin
                bank_open[sd.SDRAM_BA] <= 1'b1;
                open_row[sd.SDRAM_BA]  <= sd.SDRAM_A;
            end
            if (cmd_pre) begin
                if (sd.SDRAM_A[10]) bank_open <= 4'd0;
                else                bank_open[sd.SDRAM_BA] <= 1'b0;
            end
            if (cmd_ref) refresh_cnt <= refresh_cnt + 16'd1;
            if (cmd_lmr) begin
                mode_reg   <= sd.SDRAM_A;
                mode_valid <= 1'b1;
            end
            if (err_set && !err) begin
                err      <= 1'b1;
                err_code <= err_val;
            end
`ifdef SDRAM_TIMING_CHECK_EN
            for (int b = 0; b < 4; b++) begin
                if (cmd_act && (sd.SDRAM_BA == 2'(b)))
                    trcd_cnt[b] <= 8'd1;
                else if (trcd_cnt[b] < TRCD_C)
                    trcd_cnt[b] <= trcd_cnt[b] + 8'd1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: read words are queued with their due edge and
// checked by an independent negedge monitor; status outputs are checked inline.
module tb_sdram_responder;
    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_LMR = 4'b0000;
    localparam logic [3:0] C_BST = 4'b0110;

    logic        clk;
    logic        reset_n;
    logic [12:0] mode_reg;
    logic        mode_valid;
    logic [15:0] refresh_cnt;
    logic        err;
    logic [2:0]  err_code;

    sdram_responder_if sd ();

    sdram_responder #(.MEM_AW(12), .TRCD(3)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sd          (sd),
        .mode_reg    (mode_reg),
        .mode_valid  (mode_valid),
        .refresh_cnt (refresh_cnt),
        .err         (err),
        .err_code    (err_code)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t_last = 0;
    logic [15:0] exp_q[$];
    int          exp_t[$];

    // clock / cycle counter (cyc = number of rising edges so far)
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    task automatic nop(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one command for exactly one edge; t_last records the edge number sampling it.
    task automatic drive(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                         input logic [15:0] d, input logic [1:0] dqm);
        {sd.SDRAM_nCS, sd.SDRAM_nRAS, sd.SDRAM_nCAS, sd.SDRAM_nWE} = c;
        sd.SDRAM_BA   = ba;
        sd.SDRAM_A    = a;
        sd.dq_in      = d;
        sd.SDRAM_DQMH = dqm[1];
        sd.SDRAM_DQML = dqm[0];
        t_last = cyc + 1;
        @(negedge clk);
        {sd.SDRAM_nCS, sd.SDRAM_nRAS, sd.SDRAM_nCAS, sd.SDRAM_nWE} = C_NOP;
    endtask

    task automatic wdata(input logic [15:0] d);
        sd.dq_in = d;
        @(negedge clk);
    endtask

    task automatic push_rd(input logic [15:0] d, input int due_edge);
        exp_q.push_back(d);
        exp_t.push_back(due_edge);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        nop(3);
        reset_n = 1'b1;
        nop(1);
    endtask

    // scoreboard monitor: value seen at this negedge belongs to the cycle ending at edge cyc+1
    always @(negedge clk) begin
        logic [15:0] d;
        int          t;
        if (reset_n) begin
            if (sd.dq_oe) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_read: dq_oe=1 dq_out=%h at edge %0d, no word due", sd.dq_out, cyc + 1);
                end else begin
                    d = exp_q.pop_front();
                    t = exp_t.pop_front();
                    if (sd.dq_out !== d || t != cyc + 1) begin
                        errors++;
                        $display("FAIL read_word: got %h at edge %0d, expected %h at edge %0d", sd.dq_out, cyc + 1, d, t);
                    end
                end
            end else if (exp_t.size() != 0 && exp_t[0] < cyc + 1) begin
                checks++;
                errors++;
                d = exp_q.pop_front();
                t = exp_t.pop_front();
                $display("FAIL missing_read: dq_oe=0 at edge %0d, expected %h at edge %0d", cyc + 1, d, t);
            end
        end
    end

    initial begin
        sd.SDRAM_CKE = 1'b1;
        {sd.SDRAM_nCS, sd.SDRAM_nRAS, sd.SDRAM_nCAS, sd.SDRAM_nWE} = C_NOP;
        sd.SDRAM_BA   = 2'd0;
        sd.SDRAM_A    = 13'd0;
        sd.SDRAM_DQML = 1'b0;
        sd.SDRAM_DQMH = 1'b0;
        sd.dq_in      = 16'd0;
        reset_n       = 1'b0;
        @(negedge clk);
        do_reset();

        check("rst_dq_oe",       16'(sd.dq_oe), 16'd0);
        check("rst_dq_out",      sd.dq_out, 16'd0);
        check("rst_mode_reg",    16'(mode_reg), 16'd0);
        check("rst_mode_valid",  16'(mode_valid), 16'd0);
        check("rst_refresh_cnt", refresh_cnt, 16'd0);
        check("rst_err",         16'(err), 16'd0);
        check("rst_err_code",    16'(err_code), 16'd0);

        // CL2, BL1, single-location writes
        drive(C_LMR, 2'd0, 13'h220, 16'h0, 2'b00); nop(1);
        check("mode_reg_220", 16'(mode_reg), 16'h0220);
        check("mode_valid",   16'(mode_valid), 16'd1);
        drive(C_ACT, 2'd0, 13'd5, 16'h0, 2'b00); nop(2);
        drive(C_WR, 2'd0, 13'd3, 16'hA55A, 2'b00); nop(1);
        drive(C_RD, 2'd0, 13'd3, 16'h0, 2'b00);
        push_rd(16'hA55A, t_last + 2);
        nop(5);

        // CL3
        drive(C_LMR, 2'd0, 13'h230, 16'h0, 2'b00); nop(1);
        drive(C_RD, 2'd0, 13'd3, 16'h0, 2'b00);
        push_rd(16'hA55A, t_last + 3);
        nop(6);

        // byte masking: upper byte kept from the first write
        drive(C_WR, 2'd0, 13'd10, 16'h1234, 2'b00); nop(1);
        drive(C_WR, 2'd0, 13'd10, 16'hFFFF, 2'b10); nop(1);
        drive(C_RD, 2'd0, 13'd10, 16'h0, 2'b00);
        push_rd(16'h12FF, t_last + 3);
        nop(6);

        // BL4 CL2: burst write cols 4..7, wrapped burst read from col 6
        drive(C_LMR, 2'd0, 13'h022, 16'h0, 2'b00); nop(1);
        drive(C_WR, 2'd0, 13'd4, 16'd1, 2'b00);
        wdata(16'd2); wdata(16'd3); wdata(16'd4);
        nop(1);
        drive(C_RD, 2'd0, 13'd6, 16'h0, 2'b00);
        push_rd(16'd3, t_last + 2);
        push_rd(16'd4, t_last + 3);
        push_rd(16'd1, t_last + 4);
        push_rd(16'd2, t_last + 5);
        nop(7);
        check("err_after_bursts", 16'(err), 16'd0);

        // precharge all, two refreshes
        drive(C_PRE, 2'd0, 13'h400, 16'h0, 2'b00); nop(1);
        drive(C_REF, 2'd0, 13'h0, 16'h0, 2'b00); nop(1);
        drive(C_REF, 2'd0, 13'h0, 16'h0, 2'b00); nop(1);
        check("refresh_cnt_2", refresh_cnt, 16'd2);
        check("err_after_ref", 16'(err), 16'd0);

        // burst terminate two edges into a BL4 read: only words 0 and 1 appear
        drive(C_ACT, 2'd0, 13'd5, 16'h0, 2'b00); nop(2);
        drive(C_RD, 2'd0, 13'd4, 16'h0, 2'b00);
        push_rd(16'd1, t_last + 2);
        push_rd(16'd2, t_last + 3);
        nop(1);
        drive(C_BST, 2'd0, 13'h0, 16'h0, 2'b00);
        nop(6);
        check("err_after_bst", 16'(err), 16'd0);

        // read of a closed bank, then a double ACTIVE must not overwrite the code
        do_reset();
        check("rst2_refresh_cnt", refresh_cnt, 16'd0);
        check("rst2_mode_valid",  16'(mode_valid), 16'd0);
        drive(C_LMR, 2'd0, 13'h220, 16'h0, 2'b00); nop(1);
        drive(C_RD, 2'd1, 13'd0, 16'h0, 2'b00); nop(3);
        check("err_closed",      16'(err), 16'd1);
        check("err_code_closed", 16'(err_code), 16'd1);
        drive(C_ACT, 2'd1, 13'd1, 16'h0, 2'b00); nop(1);
        drive(C_ACT, 2'd1, 13'd2, 16'h0, 2'b00); nop(1);
        check("err_code_sticky", 16'(err_code), 16'd1);
        check("err_sticky",      16'(err), 16'd1);

        // tRCD: access two edges after ACTIVE
        do_reset();
        drive(C_LMR, 2'd0, 13'h220, 16'h0, 2'b00); nop(1);
        drive(C_ACT, 2'd2, 13'd0, 16'h0, 2'b00); nop(1);
        drive(C_WR, 2'd2, 13'd0, 16'h5A5A, 2'b00); nop(2);
`ifdef SDRAM_TIMING_CHECK_EN
        check("trcd_early_err",  16'(err), 16'd1);
        check("trcd_early_code", 16'(err_code), 16'd5);
`else
        check("trcd_early_err",  16'(err), 16'd0);
        check("trcd_early_code", 16'(err_code), 16'd0);
`endif

        // tRCD: access three edges after ACTIVE, then read it back
        do_reset();
        drive(C_LMR, 2'd0, 13'h220, 16'h0, 2'b00); nop(1);
        drive(C_ACT, 2'd2, 13'd0, 16'h0, 2'b00); nop(2);
        drive(C_WR, 2'd2, 13'd0, 16'hBEEF, 2'b00); nop(1);
        drive(C_RD, 2'd2, 13'd0, 16'h0, 2'b00);
        push_rd(16'hBEEF, t_last + 2);
        nop(5);
        check("trcd_ok_err",  16'(err), 16'd0);
        check("trcd_ok_code", 16'(err_code), 16'd0);

        nop(4);
        check("exp_q_drained", 16'(exp_q.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sdram_responder.md
Name: sdram_responder

Overview:
- Synthesizable responder model of an MT48LC16M16-class SDRAM: decodes the command bus driven by the core's SDRAM controller and answers with correct CAS-latency read data.
- Backed by an on-chip block RAM; tracks mode register, per-bank open rows, refreshes and protocol errors.
- Used in simulation and as an FPGA loopback target for controller bring-up; it is the chip-side end of the controller's SDRAM pin interface.

Parameters:
- MEM_AW, 12, word-address width of backing RAM (2^MEM_AW x 16 bits).
- TRCD, 3, minimum cycles from ACTIVE to READ/WRITE on the same bank (timing-check feature only).

Ports:
- clk  in  1  SDRAM clock; all sampling on rising edge.
- reset_n  in  1  synchronous active-low reset.
- SDRAM_CKE  in  1  clock enable; low = command and burst state frozen.
- SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE  in  1 each  command bus.
- SDRAM_BA  in  2  bank select.
- SDRAM_A  in  13  multiplexed address.
- SDRAM_DQML, SDRAM_DQMH  in  1 each  write byte masks (1 = byte not written).
- dq_in  in  16  data bus as seen from the chip.
- dq_out  out  16  read data to drive.
- dq_oe  out  1  drive enable for dq_out.
- mode_reg  out  13  last loaded mode register.
- mode_valid  out  1  at least one LOAD MODE received since reset.
- refresh_cnt  out  16  auto-refresh count, wraps at 0xFFFF.
- err  out  1  sticky protocol error.
- err_code  out  3  first error captured: 1 no open row, 2 ACTIVE on open bank, 3 access before mode load, 4 REFRESH with bank open, 5 tRCD violation.

Behaviour:
- Reset (reset_n=0 at edge): dq_oe=0, dq_out=0, mode_reg=0, mode_valid=0, refresh_cnt=0, err=0, err_code=0, all banks closed, burst idle. RAM contents retained.
- Command {nCS,nRAS,nCAS,nWE} sampled when CKE=1: 1xxx/0111 NOP; 0011 ACTIVE (bank BA opens row A); 0101 READ; 0100 WRITE; 0010 PRECHARGE (A10=1 all banks, else BA); 0001 AUTO_REFRESH (refresh_cnt+1); 0000 LOAD MODE (mode_reg<=A, mode_valid<=1); 0110 BURST TERMINATE (stops burst).
- Mode decode: BL=A[2:0] 000/001/010/011 -> 1/2/4/8, others treated as 1; CL=A[6:4], only 2 or 3, others treated as 2; A[9]=1 single-location writes.
- Word address = low MEM_AW bits of {BA, open_row[BA], A[8:0]}.
- READ at edge T0: word k of burst is valid on dq_out with dq_oe=1 in the cycle ending at edge T0+CL+k, k=0..BL-1; dq_oe=0 otherwise. Column increments wrapping inside BL-aligned block. Per-word RAM read completes within the CL pipeline.
- WRITE at edge T0: dq_in written at T0 (k=0) and at following BL-1 edges (1 if A[9]); byte lanes masked by DQMH/DQML sampled at each edge; dq_oe=0.
- A10=1 on READ/WRITE: bank closes after the last burst word.
- New READ/WRITE/BURST TERMINATE/PRECHARGE of the bursting bank truncates the current burst on that edge; already-queued read words in the CL pipe still appear, later words dropped.
- Errors (first only latched, err sticky until reset, access still performed except code 1 which is ignored): READ/WRITE to closed bank ->1; ACTIVE on open bank ->2 (row replaced); READ/WRITE while mode_valid=0 ->3; REFRESH with any bank open ->4.
- CKE=0: pipeline and burst counter hold; dq_oe holds value.

Optional Feature:
- SDRAM_TIMING_CHECK_EN defined: per-bank counter from ACTIVE; READ/WRITE issued earlier than TRCD cycles after ACTIVE sets err_code 5. Undefined: no counters, code 5 never produced.

Test Plan:
- Reset, LOAD MODE A=0x220 (CL2, BL1, single write), ACTIVE BA0 row 5, WRITE col 3 dq_in=0xA55A DQM=00, READ col 3 -> dq_oe=1, dq_out=0xA55A exactly at T0+2; mode_reg=0x220.
- Same with CL3 (A=0x230) -> data at T0+3, dq_oe low at T0+2 and T0+4.
- Write 0x1234, then WRITE 0xFFFF with DQMH=1,DQML=0 -> read returns 0x12FF.
- BL=4 mode (A=0x022), preload cols 4..7 = 1,2,3,4, READ col 6 -> 3,4,1,2 on consecutive cycles from T0+2.
- READ with no ACTIVE -> err=1, err_code=1, dq_oe stays 0; later ACTIVE on open bank keeps err_code=1.
- With SDRAM_TIMING_CHECK_EN, TRCD=3: READ 2 cycles after ACTIVE -> err_code=5; 3 cycles -> no error; two REFRESH with banks closed -> refresh_cnt=2.
